// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: mode encodings, default widths,
// configuration handshake state and the per-channel LED drive decode.
package led_pwm_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 24;
  localparam int DEF_PWM_W  = 4;
  localparam int CH_IDX_W   = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_t;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_BUSY = 1'b1
  } cfg_state_t;

  function automatic logic led_drive(input led_mode_t mode,
                                     input logic blink,
                                     input logic pwm_on);
    logic drv;
    drv = 1'b0;
    case (mode)
      MODE_OFF:   drv = 1'b0;
      MODE_ON:    drv = 1'b1;
      MODE_BLINK: drv = blink;
      MODE_PWM:   drv = pwm_on;
      default:    drv = 1'b0;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// Configuration write port of the LED PWM bank.
// Handshake: a write transfers on a rising edge where cfg_valid and cfg_ready
// are both 1; the master holds cfg_ch/mode/div/duty stable while cfg_valid=1.
interface led_pwm_bank_if
  import led_pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PWM_W = DEF_PWM_W
) ();

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_IDX_W-1:0] cfg_ch;
  led_mode_t           cfg_mode;
  logic [CNT_W-1:0]    cfg_div;
  logic [PWM_W-1:0]    cfg_duty;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_div, cfg_duty,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: prescaler, blink toggle, PWM phase counter and the
// registered LED drive. A write reloads config and restarts all counters.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PWM_W = DEF_PWM_W
) (
  input  logic             clkout,
  input  logic             btn_n,
  input  logic             en,
  input  logic             wr_en,
  input  led_mode_t        wr_mode,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [PWM_W-1:0] wr_duty,
  output logic             led
);

  led_mode_t        mode_q;
  logic [CNT_W-1:0] div_q;
  logic [PWM_W-1:0] duty_q;
  logic [CNT_W-1:0] presc_q;
  logic [PWM_W-1:0] phase_q;
  logic             blink_q;
  logic             led_q;

  logic tick;
  logic pwm_on;
  logic led_d;

  // LED drive is computed from the current state and registered, so a state
  // change appears on led one cycle later.
  always_comb begin
    tick   = (presc_q == div_q);
    pwm_on = (phase_q < duty_q);
    led_d  = led_drive(mode_q, blink_q, pwm_on);
  end

  always_ff @(posedge clkout) begin
    if (!btn_n) begin
      mode_q  <= MODE_OFF;
      div_q   <= '0;
      duty_q  <= '0;
      presc_q <= '0;
      phase_q <= '0;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      if (en) begin
        led_q <= led_d;
      end
      if (wr_en) begin
        mode_q  <= wr_mode;
        div_q   <= wr_div;
        duty_q  <= wr_duty;
        presc_q <= '0;
        phase_q <= '0;
        blink_q <= 1'b0;
      end else if (en) begin
        presc_q <= tick ? '0 : presc_q + CNT_W'(1);
        if (tick) begin
          blink_q <= ~blink_q;
          phase_q <= phase_q + PWM_W'(1);
        end
      end
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of independent LED channels behind a single valid/ready config port;
// the top owns the write handshake, channel decode and error pulse.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PWM_W  = DEF_PWM_W
) (
  input  logic                clkout,
  input  logic                btn_n,
  input  logic                en,
  led_pwm_bank_if.slave       cfg,
  output logic [NUM_CH-1:0]   led,
  output cfg_state_t          dbg_state
);

  cfg_state_t state_q;
  cfg_state_t state_d;
  logic       accept;
  logic       ch_ok;
  logic       err_q;

  // Ready drops for exactly one cycle after each accept.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        accept = cfg.cfg_valid;
        if (cfg.cfg_valid) state_d = CFG_BUSY;
      end
      CFG_BUSY: state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clkout) begin
    if (!btn_n) begin
      state_q <= CFG_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !ch_ok;
    end
  end

  // Extend by one bit so NUM_CH=16 compares correctly against a 4-bit index.
  assign ch_ok = ({1'b0, cfg.cfg_ch} < (CH_IDX_W + 1)'(NUM_CH));

  assign cfg.cfg_ready = (state_q == CFG_IDLE);
  assign cfg.cfg_err   = err_q;
  assign dbg_state     = state_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = accept && (cfg.cfg_ch == CH_IDX_W'(i));

    led_pwm_channel #(
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_ch (
      .clkout  (clkout),
      .btn_n   (btn_n),
      .en      (en),
      .wr_en   (wr_en),
      .wr_mode (cfg.cfg_mode),
      .wr_div  (cfg.cfg_div),
      .wr_duty (cfg.cfg_duty),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank with NUM_CH=4, CNT_W=8, PWM_W=4.
module tb_led_pwm_bank;
  import led_pwm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int PWM_W  = 4;

  logic              clkout = 1'b0;
  logic              btn_n;
  logic              en;
  logic [NUM_CH-1:0] led;
  cfg_state_t        dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  led_pwm_bank_if #(.CNT_W(CNT_W), .PWM_W(PWM_W)) cfg_if ();

  led_pwm_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PWM_W  (PWM_W)
  ) dut (
    .clkout    (clkout),
    .btn_n     (btn_n),
    .en        (en),
    .cfg       (cfg_if.slave),
    .led       (led),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clkout = ~clkout;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clkout);
    #1;
  endtask

  task automatic set_write(input int ch, input led_mode_t m, input int div, input int duty);
    cfg_if.cfg_ch   = 4'(ch);
    cfg_if.cfg_mode = m;
    cfg_if.cfg_div  = 8'(div);
    cfg_if.cfg_duty = 4'(duty);
  endtask

  // Presents one write in an idle cycle; returns in the cycle after the accept.
  task automatic do_write(input int ch, input led_mode_t m, input int div, input int duty);
    set_write(ch, m, div, duty);
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    btn_n = 1'b0;
    en    = 1'b1;
    set_write(0, MODE_ON, 0, 0);
    cfg_if.cfg_valid = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (led !== 4'b0000) $display("FAIL reset_led got=%b exp=0000", led); else pass_cnt++;
    total_cnt++;
    if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); else pass_cnt++;
    total_cnt++;
    if (cfg_if.cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", cfg_if.cfg_err); else pass_cnt++;
    total_cnt++;
    if (dbg_state !== CFG_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, CFG_IDLE); else pass_cnt++;
    cfg_if.cfg_valid = 1'b0;
    btn_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (led !== 4'b0000) $display("FAIL reset_no_write k=%0d got=%b exp=0000", k, led); else pass_cnt++;
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    do_write(1, MODE_BLINK, 3, 0);
    total_cnt++;
    if (dbg_state !== CFG_BUSY) $display("FAIL blink_busy got=%0d exp=%0d", dbg_state, CFG_BUSY); else pass_cnt++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = 4'b0000;
      exp[1] = (((k - 1) / 4) % 2) == 1;
      total_cnt++;
      if (led !== exp) $display("FAIL blink k=%0d got=%b exp=%b", k, led, exp); else pass_cnt++;
    end
    do_write(1, MODE_OFF, 0, 0);
    tick();
    total_cnt++;
    if (led !== 4'b0000) $display("FAIL blink_off got=%b exp=0000", led); else pass_cnt++;
  endtask

  task automatic test_pwm();
    logic [3:0] exp;
    do_write(2, MODE_PWM, 0, 4);
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp = 4'b0000;
      exp[2] = ((k - 1) % 16) < 4;
      total_cnt++;
      if (led !== exp) $display("FAIL pwm4 k=%0d got=%b exp=%b", k, led, exp); else pass_cnt++;
    end
    do_write(2, MODE_PWM, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      total_cnt++;
      if (led !== 4'b0000) $display("FAIL pwm0 k=%0d got=%b exp=0000", k, led); else pass_cnt++;
    end
    do_write(2, MODE_PWM, 0, 15);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = 4'b0000;
      exp[2] = ((k - 1) % 16) < 15;
      total_cnt++;
      if (led !== exp) $display("FAIL pwm15 k=%0d got=%b exp=%b", k, led, exp); else pass_cnt++;
    end
    do_write(2, MODE_OFF, 0, 0);
    tick();
    total_cnt++;
    if (led !== 4'b0000) $display("FAIL pwm_off got=%b exp=0000", led); else pass_cnt++;
  endtask

  task automatic test_bad_channel();
    do_write(3, MODE_ON, 0, 0);
    tick();
    total_cnt++;
    if (led !== 4'b1000) $display("FAIL bad_pre_led got=%b exp=1000", led); else pass_cnt++;
    total_cnt++;
    if (cfg_if.cfg_err !== 1'b0) $display("FAIL bad_pre_err got=%b exp=0", cfg_if.cfg_err); else pass_cnt++;
    do_write(5, MODE_ON, 0, 0);
    total_cnt++;
    if (cfg_if.cfg_err !== 1'b1) $display("FAIL bad_err_pulse got=%b exp=1", cfg_if.cfg_err); else pass_cnt++;
    tick();
    total_cnt++;
    if (cfg_if.cfg_err !== 1'b0) $display("FAIL bad_err_clear got=%b exp=0", cfg_if.cfg_err); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (led !== 4'b1000) $display("FAIL bad_led k=%0d got=%b exp=1000", k, led); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    led_mode_t modes [4] = '{MODE_ON, MODE_ON, MODE_ON, MODE_OFF};
    set_write(0, modes[0], 0, 0);
    cfg_if.cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b1) $display("FAIL b2b_ready_hi i=%0d got=%b exp=1", i, cfg_if.cfg_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (cfg_if.cfg_ready !== 1'b0) $display("FAIL b2b_ready_lo i=%0d got=%b exp=0", i, cfg_if.cfg_ready); else pass_cnt++;
      if (i < 3) set_write(i + 1, modes[i + 1], 0, 0);
      else cfg_if.cfg_valid = 1'b0;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (led !== 4'b0111) $display("FAIL b2b_led k=%0d got=%b exp=0111", k, led); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_enable_and_reset();
    logic [3:0] exp;
    btn_n = 1'b0;
    tick();
    total_cnt++;
    if (led !== 4'b0000) $display("FAIL en_reset_led got=%b exp=0000", led); else pass_cnt++;
    btn_n = 1'b1;
    do_write(0, MODE_BLINK, 2, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = {3'b000, (((k - 1) / 3) % 2) == 1};
      total_cnt++;
      if (led !== exp) $display("FAIL en_run k=%0d got=%b exp=%b", k, led, exp); else pass_cnt++;
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total_cnt++;
      if (led !== 4'b0001) $display("FAIL en_freeze k=%0d got=%b exp=0001", k, led); else pass_cnt++;
    end
    en = 1'b1;
    for (int k = 6; k <= 15; k++) begin
      tick();
      exp = {3'b000, (((k - 1) / 3) % 2) == 1};
      total_cnt++;
      if (led !== exp) $display("FAIL en_resume k=%0d got=%b exp=%b", k, led, exp); else pass_cnt++;
    end
    btn_n = 1'b0;
    tick();
    btn_n = 1'b1;
    total_cnt++;
    if (led !== 4'b0000) $display("FAIL mid_reset_led got=%b exp=0000", led); else pass_cnt++;
    total_cnt++;
    if (cfg_if.cfg_ready !== 1'b1) $display("FAIL mid_reset_ready got=%b exp=1", cfg_if.cfg_ready); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      tick();
      total_cnt++;
      if (led !== 4'b0000) $display("FAIL mid_reset_off k=%0d got=%b exp=0000", k, led); else pass_cnt++;
    end
  endtask

  initial begin
    btn_n = 1'b0;
    en    = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    set_write(0, MODE_OFF, 0, 0);
    tick();
    test_reset();
    test_blink();
    test_pwm();
    test_bad_channel();
    test_back_to_back();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent LED channels, range 1..16.
REQ-002 Parameter CNT_W, default 24: width of each channel's prescaler counter and divider value.
REQ-003 Parameter PWM_W, default 4: width of each channel's PWM phase counter and duty value.
REQ-004 CLK  input  1: single clock, sourced from the PLL output; all logic SHALL be on its rising edge.
REQ-005 BTN_N  input  1: reset, synchronous, active-low.
REQ-006 en  input  1: global run enable; 0 freezes all channel counters.
REQ-007 cfg_valid  input  1: configuration write request.
REQ-008 cfg_ready  output  1: block can accept a write this cycle.
REQ-009 cfg_ch  input  4: target channel index.
REQ-010 cfg_mode  input  2: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 cfg_div  input  CNT_W: prescaler terminal count; tick period = cfg_div+1 cycles.
REQ-012 cfg_duty  input  PWM_W: PWM on-slots per frame.
REQ-013 cfg_err  output  1: one-cycle pulse on an accepted write with cfg_ch >= NUM_CH.
REQ-014 led  output  NUM_CH: registered LED drive, bit i = channel i, active-high.

Function
REQ-015 Write accepted at a rising edge where cfg_valid=1 and cfg_ready=1.
REQ-016 cfg_ready SHALL be 0 for exactly the cycle after an accept and 1 otherwise; held cfg_valid therefore gives one accept per two cycles.
REQ-017 On accept with valid cfg_ch, that channel's mode/div/duty registers load and its prescaler, PWM counter and blink state clear to 0 at the same edge; other channels are unaffected.
REQ-018 On accept with invalid cfg_ch, no channel state changes and cfg_err is 1 for the following cycle only.
REQ-019 Prescaler: when en=1, counts 0..div, then wraps to 0 and asserts an internal tick for that cycle; div=0 ticks every cycle.
REQ-020 en=0: prescalers, PWM counters and blink states hold; led holds its value; config writes are still accepted.
REQ-021 OFF: led bit 0. ON: led bit 1 (counters run but are unused).
REQ-022 BLINK: blink state toggles on each tick; led bit = blink state; full LED period = 2*(div+1) cycles.
REQ-023 PWM: phase counter increments on each tick, wraps 2^PWM_W-1 -> 0; led bit = (phase < duty); duty=0 never on; duty=2^PWM_W-1 off for one slot per frame.
REQ-024 led is registered: the new mode is visible on led one cycle after the accepting edge.
REQ-025 All arithmetic unsigned; counters wrap modulo their width without saturation.

Reset
REQ-026 BTN_N=0 at a rising edge SHALL clear all modes to OFF, div and duty to 0, all counters and blink states to 0, led to 0, cfg_err to 0, cfg_ready to 1.
REQ-027 Reset SHALL take priority over a simultaneous write and over any operation in progress; the first accept is possible in the first cycle with BTN_N=1.

Structure
REQ-028 Mode encodings (OFF/ON/BLINK/PWM) and default widths SHALL live in shared package led_pwm_pkg.
REQ-029 Per-channel prescaler, PWM counter and output logic SHALL be sub-module led_pwm_channel, instantiated NUM_CH times by generate; the top holds the config handshake and decode.

Verification (NUM_CH=4, CNT_W=8, PWM_W=4)
REQ-030 BTN_N=0 for 2 cycles with cfg_valid=1 -> led=0000, cfg_ready=1, cfg_err=0, no write takes effect.
REQ-031 Write ch1 BLINK div=3, en=1 -> led[1] rises 5 cycles after accept, then toggles every 4 cycles; other bits 0.
REQ-032 Write ch2 PWM div=0 duty=4 -> led[2] high 4 of every 16 cycles; rewrite duty=0 -> led[2] stays 0.
REQ-033 Write cfg_ch=5 -> cfg_err=1 for one cycle, led and all channel states unchanged.
REQ-034 cfg_valid held high with 4 different writes -> accepts on alternate cycles, cfg_ready pattern 1,0,1,0..., all four channels configured.
REQ-035 ch0 BLINK div=2 running; en=0 for 10 cycles -> led[0] frozen, then resumes phase; BTN_N pulse mid-blink -> led=0000, ch0 back to OFF.
